// File: rtl/defs.sv
// Shared particle/grid types: 64x64 periodic grid, 12-bit position fractions,
// 35-bit signed field components with 27 fractional bits.
package defs;
    localparam int PFRAC          = 12;
    localparam int GRID_BITS      = 6;
    localparam int GRID_ADDRWIDTH = 2 * GRID_BITS;
    localparam int EWIDTH         = 35;
    localparam int PID_W          = 14;

    typedef struct packed {
        logic [GRID_BITS-1:0] whole;
        logic [PFRAC-1:0]     fraction;
    } pos_t;

    typedef struct packed {
        logic [PID_W-1:0] id;
        pos_t             y;
        pos_t             x;
    } particle_t;

    localparam int PSIZE = $bits(particle_t);

    typedef logic signed [EWIDTH-1:0] elect_t;

    typedef struct packed {
        elect_t y;
        elect_t x;
    } evec_t;
endpackage

// File: rtl/field_gather_if.sv
// Particle in, E-memory read port and interpolated-field out for field_gather.
// master = the gather block, slave = its surroundings (upstream, memory, pusher).
interface field_gather_if;
    import defs::*;

    particle_t                 in_particle;
    logic                      in_valid;
    logic                      in_ready;
    logic                      rd_en;
    logic [GRID_ADDRWIDTH-1:0] rd_addr;
    evec_t                     rd_data;
    particle_t                 out_particle;
    evec_t                     out_e;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        input  in_particle, in_valid, rd_data, out_ready,
        output in_ready, rd_en, rd_addr, out_particle, out_e, out_valid
    );

    modport slave (
        output in_particle, in_valid, rd_data, out_ready,
        input  in_ready, rd_en, rd_addr, out_particle, out_e, out_valid
    );
endinterface

// File: rtl/field_gather.sv
// Bilinear gather of the 4 grid nodes around a particle; result 5+RD_LATENCY cycles after accept.
// One particle in flight: in_ready drops from accept until the output handshake completes.
module field_gather
    import defs::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    field_gather_if.master bus
);
    localparam int ACC_W = EWIDTH + 26;
    localparam int WGT_W = 25;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

    state_t                    state;
    logic [GRID_BITS-1:0]      col_q;
    logic [GRID_BITS-1:0]      row_q;
    logic [PFRAC-1:0]          fx_q;
    logic [PFRAC-1:0]          fy_q;
    logic [1:0]                issue_k;
    logic                      tag_vld [RD_LATENCY];
    logic [1:0]                tag_k   [RD_LATENCY];
    logic signed [ACC_W-1:0]   acc_x;
    logic signed [ACC_W-1:0]   acc_y;

    logic                      rd_en_q;
    logic [GRID_ADDRWIDTH-1:0] rd_addr_q;
    particle_t                 out_particle_q;
    evec_t                     out_e_q;
    logic                      out_valid_q;

    logic                      accept;
    logic                      ret_vld;
    logic [1:0]                ret_k;
    evec_t                     rd_dat;
    logic [PFRAC:0]            gx0, gx1, gy0, gy1;
    logic [WGT_W-1:0]          w_sel;
    logic [ACC_W-1:0]          prod_x, prod_y;
    logic signed [ACC_W-1:0]   acc_x_nxt, acc_y_nxt;

    function automatic logic [WGT_W-1:0] wmul(input logic [PFRAC:0] a, input logic [PFRAC:0] b);
        return {{(WGT_W-PFRAC-1){1'b0}}, a} * {{(WGT_W-PFRAC-1){1'b0}}, b};
    endfunction

    // Corner k: bit 0 steps the column, bit 1 steps the row; both wrap on the periodic grid.
    function automatic logic [GRID_ADDRWIDTH-1:0] corner_addr(input logic [GRID_BITS-1:0] col,
                                                              input logic [GRID_BITS-1:0] row,
                                                              input logic [1:0]           k);
        logic [GRID_BITS-1:0] c;
        logic [GRID_BITS-1:0] r;
        c = col + {{(GRID_BITS-1){1'b0}}, k[0]};
        r = row + {{(GRID_BITS-1){1'b0}}, k[1]};
        return {r, c};
    endfunction

    assign bus.in_ready     = (state == IDLE) && !rst;
    assign bus.rd_en        = rd_en_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.out_particle = out_particle_q;
    assign bus.out_e        = out_e_q;
    assign bus.out_valid    = out_valid_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign ret_vld = tag_vld[RD_LATENCY-1];
    assign ret_k   = tag_k[RD_LATENCY-1];
    assign rd_dat  = bus.rd_data;

    always_comb begin
        gx1   = {1'b0, fx_q};
        gy1   = {1'b0, fy_q};
        gx0   = 13'd4096 - gx1;
        gy0   = 13'd4096 - gy1;
        w_sel = '0;
        case (ret_k)
            2'd0: w_sel = wmul(gx0, gy0);
            2'd1: w_sel = wmul(gx1, gy0);
            2'd2: w_sel = wmul(gx0, gy1);
            2'd3: w_sel = wmul(gx1, gy1);
            default: w_sel = '0;
        endcase
        // Both operands widened to the accumulator width, so the low bits are the signed product.
        prod_x = {{(ACC_W-EWIDTH){rd_dat.x[EWIDTH-1]}}, rd_dat.x} * {{(ACC_W-WGT_W){1'b0}}, w_sel};
        prod_y = {{(ACC_W-EWIDTH){rd_dat.y[EWIDTH-1]}}, rd_dat.y} * {{(ACC_W-WGT_W){1'b0}}, w_sel};
        acc_x_nxt = acc_x + $signed(prod_x);
        acc_y_nxt = acc_y + $signed(prod_y);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            fx_q           <= '0;
            fy_q           <= '0;
            issue_k        <= '0;
            acc_x          <= '0;
            acc_y          <= '0;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            out_particle_q <= '0;
            out_e_q        <= '0;
            out_valid_q    <= 1'b0;
            for (int n = 0; n < RD_LATENCY; n++) begin
                tag_vld[n] <= 1'b0;
                tag_k[n]   <= '0;
            end
        end else begin
            // Tags follow each read so returns are matched to their corner weight.
            tag_vld[0] <= rd_en_q;
            tag_k[0]   <= issue_k;
            for (int n = 1; n < RD_LATENCY; n++) begin
                tag_vld[n] <= tag_vld[n-1];
                tag_k[n]   <= tag_k[n-1];
            end

            if (ret_vld) begin
                acc_x <= acc_x_nxt;
                acc_y <= acc_y_nxt;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        out_particle_q <= bus.in_particle;
                        col_q          <= bus.in_particle.x.whole;
                        row_q          <= bus.in_particle.y.whole;
                        fx_q           <= bus.in_particle.x.fraction;
                        fy_q           <= bus.in_particle.y.fraction;
                        acc_x          <= '0;
                        acc_y          <= '0;
                        issue_k        <= 2'd0;
                        rd_en_q        <= 1'b1;
                        rd_addr_q      <= {bus.in_particle.y.whole, bus.in_particle.x.whole};
                        state          <= FETCH;
                    end
                end
                FETCH: begin
                    if (issue_k == 2'd3) begin
                        rd_en_q <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        issue_k   <= issue_k + 2'd1;
                        rd_addr_q <= corner_addr(col_q, row_q, issue_k + 2'd1);
                    end
                end
                DRAIN: begin
                    if (ret_vld && (ret_k == 2'd3)) begin
                        // Bits above the binary point of the 2^24-scaled sum: floor division.
                        out_e_q.x   <= acc_x_nxt[EWIDTH+23:24];
                        out_e_q.y   <= acc_y_nxt[EWIDTH+23:24];
                        out_valid_q <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
